// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480 VGA raster constants and the shared counter type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int CNT_W        = 10;

    localparam int H_SYNC       = 96;
    localparam int H_BP         = 62;
    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 2;

    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;

    localparam int H_TOTAL      = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_ACT_START  = H_SYNC + H_BP;
    localparam int H_ACT_END    = H_ACT_START + H_ACTIVE;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [CNT_W-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_if.sv
// ============================================================================
// Module      : vga_timing_if
// Description : Raster timing bundle from the generator to the pixel logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_if;
    import vga_timing_pkg::*;

    logic   pix_en;
    count_t hcount;
    count_t vcount;
    logic   hsync;
    logic   vsync;
    logic   bright;
    logic   frame_start;

    modport master (
        output pix_en, hcount, vcount, hsync, vsync, bright, frame_start
    );

    modport slave (
        input  pix_en, hcount, vcount, hsync, vsync, bright, frame_start
    );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping counter with registered sync/active
//               flags decoded from the next count value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 0,
    parameter int SYNC_END   = 96,
    parameter int ACT_START  = 158,
    parameter int ACT_END    = 798
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic inc,
    output count_t    count,
    output logic      wrap,
    output logic      sync_n,
    output logic      active
);

    localparam count_t C_LAST       = count_t'(TOTAL - 1);
    localparam count_t C_SYNC_START = count_t'(SYNC_START);
    localparam count_t C_SYNC_END   = count_t'(SYNC_END);
    localparam count_t C_ACT_START  = count_t'(ACT_START);
    localparam count_t C_ACT_END    = count_t'(ACT_END);
    // Reset flags match what count = 0 decodes to.
    localparam logic   C_SYNC_N_RST = (SYNC_START == 0 && SYNC_END > 0) ? 1'b0 : 1'b1;
    localparam logic   C_ACT_RST    = (ACT_START == 0 && ACT_END > 0) ? 1'b1 : 1'b0;

    count_t r_count;
    count_t w_next;
    logic   r_sync_n;
    logic   r_active;
    logic   w_wrap;
    logic   w_in_sync;
    logic   w_in_act;

    assign w_wrap = inc && (r_count == C_LAST);

    always_comb begin
        w_next = r_count;
        if (inc) begin
            w_next = w_wrap ? '0 : r_count + count_t'(1);
        end
    end

    generate
        if (SYNC_START == 0) begin : g_sync_from_zero
            assign w_in_sync = (w_next < C_SYNC_END);
        end else begin : g_sync_window
            assign w_in_sync = (w_next >= C_SYNC_START) && (w_next < C_SYNC_END);
        end

        if (ACT_START == 0) begin : g_act_from_zero
            assign w_in_act = (w_next < C_ACT_END);
        end else begin : g_act_window
            assign w_in_act = (w_next >= C_ACT_START) && (w_next < C_ACT_END);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_sync_n <= C_SYNC_N_RST;
            r_active <= C_ACT_RST;
        end else begin
            r_count  <= w_next;
            r_sync_n <= ~w_in_sync;
            r_active <= w_in_act;
        end
    end

    assign count  = r_count;
    assign wrap   = w_wrap;
    assign sync_n = r_sync_n;
    assign active = r_active;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator (counters, syncs, bright).
//               VGA_TIMING_PIXEL_DIV_EN: divide clk by 2 for the pixel tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    vga_timing_if.master vga
);

    localparam int C_H_TOTAL      = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int C_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_H_ACT_START  = H_SYNC + H_BP;
    localparam int C_V_SYNC_START = V_ACTIVE + V_FP;

    logic r_pix_en;
    logic r_frame_start;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_active;
    logic w_v_active;

    // Without the divider the tick is held high once out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_en <= 1'b0;
        end else begin
`ifdef VGA_TIMING_PIXEL_DIV_EN
            r_pix_en <= ~r_pix_en;
`else
            r_pix_en <= 1'b1;
`endif
        end
    end

    vga_axis_counter #(
        .TOTAL      (C_H_TOTAL),
        .SYNC_START (0),
        .SYNC_END   (H_SYNC),
        .ACT_START  (C_H_ACT_START),
        .ACT_END    (C_H_ACT_START + H_ACTIVE)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (r_pix_en),
        .count  (vga.hcount),
        .wrap   (w_h_wrap),
        .sync_n (vga.hsync),
        .active (w_h_active)
    );

    vga_axis_counter #(
        .TOTAL      (C_V_TOTAL),
        .SYNC_START (C_V_SYNC_START),
        .SYNC_END   (C_V_SYNC_START + V_SYNC),
        .ACT_START  (0),
        .ACT_END    (V_ACTIVE)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_h_wrap),
        .count  (vga.vcount),
        .wrap   (w_v_wrap),
        .sync_n (vga.vsync),
        .active (w_v_active)
    );

    // Vertical wrap only fires on a horizontal wrap, i.e. the (last,last) tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
        end
    end

    assign vga.pix_en      = r_pix_en;
    assign vga.bright      = w_h_active & w_v_active;
    assign vga.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Bench for vga_timing_gen at full 640x480 size and a reduced
//               geometry, checked every clock against a tick-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_TIMING_PIXEL_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    localparam int S_HS = 4;
    localparam int S_HB = 3;
    localparam int S_HA = 10;
    localparam int S_HF = 2;
    localparam int S_VA = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned k     = 0;

    always #5 clk = ~clk;

    vga_timing_if u_if_full ();
    vga_timing_if u_if_small ();

    vga_timing_gen u_dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (u_if_full)
    );

    vga_timing_gen #(
        .H_SYNC   (S_HS),
        .H_BP     (S_HB),
        .H_ACTIVE (S_HA),
        .H_FP     (S_HF),
        .V_ACTIVE (S_VA),
        .V_FP     (S_VF),
        .V_SYNC   (S_VS),
        .V_BP     (S_VB)
    ) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (u_if_small)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (clk %0d after release, t=%0t)",
                     tag, obs, exp, k, $time);
        end
    endtask

    // Pixel ticks consumed after k clock edges since reset release.
    function automatic int unsigned ticks(input int unsigned kk);
        if (DIV) return kk / 2;
        return (kk == 0) ? 0 : kk - 1;
    endfunction

    function automatic logic pix_at(input int unsigned kk);
        if (DIV) return logic'(kk % 2 == 1);
        return logic'(kk >= 1);
    endfunction

    task automatic check_cfg(input string pfx, input int unsigned kk,
                             input int unsigned hs, input int unsigned hb,
                             input int unsigned ha, input int unsigned hf,
                             input int unsigned va, input int unsigned vf,
                             input int unsigned vs, input int unsigned vb,
                             input logic pe, input logic [9:0] hc, input logic [9:0] vc,
                             input logic hsy, input logic vsy, input logic br, input logic fs);
        int unsigned ht, vt, n, np, h, v;
        logic e_hs, e_vs, e_br, e_fs;
        ht   = hs + hb + ha + hf;
        vt   = va + vf + vs + vb;
        n    = ticks(kk);
        np   = (kk == 0) ? 0 : ticks(kk - 1);
        h    = n % ht;
        v    = (n / ht) % vt;
        e_hs = !(h < hs);
        e_vs = !(v >= va + vf && v < va + vf + vs);
        e_br = (h >= hs + hb) && (h < hs + hb + ha) && (v < va);
        e_fs = (n != np) && (n % (ht * vt) == 0);
        check_val({pfx, ".pix_en"},      32'(pe),  32'(pix_at(kk)));
        check_val({pfx, ".hcount"},      32'(hc),  h);
        check_val({pfx, ".vcount"},      32'(vc),  v);
        check_val({pfx, ".hsync"},       32'(hsy), 32'(e_hs));
        check_val({pfx, ".vsync"},       32'(vsy), 32'(e_vs));
        check_val({pfx, ".bright"},      32'(br),  32'(e_br));
        check_val({pfx, ".frame_start"}, 32'(fs),  32'(e_fs));
    endtask

    task automatic check_both();
        check_cfg("full", k, H_SYNC, H_BP, H_ACTIVE, H_FP, V_ACTIVE, V_FP, V_SYNC, V_BP,
                  u_if_full.pix_en, u_if_full.hcount, u_if_full.vcount, u_if_full.hsync,
                  u_if_full.vsync, u_if_full.bright, u_if_full.frame_start);
        check_cfg("small", k, S_HS, S_HB, S_HA, S_HF, S_VA, S_VF, S_VS, S_VB,
                  u_if_small.pix_en, u_if_small.hcount, u_if_small.vcount, u_if_small.hsync,
                  u_if_small.vsync, u_if_small.bright, u_if_small.frame_start);
    endtask

    task automatic run_cycles(input int unsigned cnt);
        for (int i = 0; i < int'(cnt); i++) begin
            @(posedge clk);
            #1;
            k++;
            check_both();
        end
    endtask

    // Drop reset between edges, check immediately, hold, then release.
    task automatic async_reset(input int unsigned hold);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        k = 0;
        check_both();
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk);
            #1;
            check_both();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_both();
        @(negedge clk);
        rst_n = 1'b1;

        // Two full-size lines plus the wrap into vcount 1/2 in either build.
        run_cycles(DIV ? 3400 : 1700);

        for (int r = 0; r < 6; r++) begin
            async_reset($urandom_range(1, 3));
            run_cycles($urandom_range(20, 700));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 VGA display path. Produces the horizontal and vertical counters, the active-low sync pulses and the `bright` display-enable. The downstream pixel generator consumes these and maps them to pixel coordinates as x = hcount − 158, y = vcount. This block is the source end of the hcount/vcount/bright interface and sits between the board clock and the pixel/RGB logic.

## Interface
- `H_SYNC`, 96, hsync pulse width in pixel ticks
- `H_BP`, 62, horizontal back porch; active video starts at hcount = H_SYNC + H_BP = 158
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 2, horizontal front porch; line total 800
- `V_ACTIVE`, 480, visible lines (vcount 0..479)
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width in lines
- `V_BP`, 33, vertical back porch; frame total 525
- `clk` input 1: board clock, 50 MHz
- `rst_n` input 1: asynchronous, active-low reset
- `pix_en` output 1: pixel tick; counters advance only when high
- `hcount` output 10: horizontal position, 0..799
- `vcount` output 10: line number, 0..524
- `hsync` output 1: active low, asserted for hcount 0..H_SYNC−1
- `vsync` output 1: active low, asserted for vcount V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC−1 (490..491)
- `bright` output 1: high when hcount is in 158..797 and vcount is in 0..479
- `frame_start` output 1: one-clk pulse on the pix_en tick that enters hcount=0, vcount=0

## Operation
- Horizontal counter: on each pix_en tick, hcount increments. At H_TOTAL−1 (799) it wraps to 0 and issues a line tick.
- Vertical counter: increments on the line tick only. At V_TOTAL−1 (524), coinciding with the line tick, it wraps to 0.
- Simultaneous wrap at (799, 524): both counters go to 0 on the same tick, and frame_start pulses.
- hsync, vsync and bright are registered. They are computed from the next-state counter values, so in every cycle they correspond exactly to the hcount/vcount presented in that same cycle.
- Counter arithmetic is 10-bit unsigned. Both totals are below 1024, so no overflow is possible. Compares use `>=` / `<` against the parameter-derived bounds.
- Reset values: hcount=0, vcount=0, hsync=0 (hcount 0 lies in the sync region), vsync=1, bright=0, frame_start=0, pix_en=0. The divider phase also resets to 0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). Counting restarts from (0,0) on the first pix_en after rst_n deasserts. No frame_start pulse is issued for this restart.

## Timing
- Pixel rate is clk/2 (25 MHz) with the divider compiled in. pix_en toggles every clk, starting high on the first clk edge after reset release.
- Outputs update only on clk edges where pix_en was high, and stay stable for 2 clks.
- Per line: hsync low for 96 ticks, bright high for 640 ticks.
- Per frame: vsync low for 2 lines (1600 ticks). One frame is 800×525 = 420000 ticks, i.e. 840000 clks.
- Latency from reset release to the first hcount change: 2 clks.

## Configuration
- `VGA_TIMING_PIXEL_DIV_EN`
  - Defined: an internal 1-bit phase register generates pix_en = clk/2, and the counters advance only on pix_en.
  - Undefined: pix_en is tied high after reset (reset value remains 0), and the counters advance on every clk, for a clock that is already at pixel rate or for simulation speed. All other behaviour is unchanged.

## Structure
- Package `vga_timing_pkg` holds:
  - default H/V constants
  - derived H_TOTAL, V_TOTAL, H_ACT_START (158), H_ACT_END (798), V_SYNC_START (490), V_SYNC_END (492)
  - the 10-bit count width
- Sub-module `vga_axis_counter` (parameters TOTAL, SYNC_START, SYNC_END, ACT_START, ACT_END; inputs clk, rst_n, inc) is instantiated twice:
  - Horizontal instance: inc = pix_en.
  - Vertical instance: inc = horizontal wrap.
  - Each instance outputs count, wrap, sync_n and active. The top ANDs the two active terms to form bright.

## Test plan
- Reset hold, then release → all outputs at reset values; first hcount=1 appears 2 clks after release (divider on).
- Run one full line → hsync low exactly for hcount 0..95; bright rises at hcount 158 and falls at 798 on vcount 0; hcount 799 wraps to 0 and vcount becomes 1.
- Run one full frame → vsync low for vcount 490..491 only; bright never high for vcount ≥ 480; frame_start pulses exactly once, 840000 clks after the previous pulse.
- Corner (799, 524) → next tick gives hcount=0 and vcount=0 together; frame_start=1 for one clk.
- Assert rst_n low at hcount=400, vcount=300 → outputs return to reset values within the same cycle; after release, counting restarts from (0,0) with no frame_start pulse.
- Build without `VGA_TIMING_PIXEL_DIV_EN` → hcount increments on every clk after release; a line takes 800 clks and a frame takes 420000 clks.
